// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: RV base
// opcodes, funct3 codes for OP-IMM shifts and the instruction format code.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;

  // funct3 values of the OP-IMM shift instructions (slli, srli/srai)
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: classifies the instruction format,
// builds the sign-extended immediate and flags unsupported encodings.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b0
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm_i32;
  logic [31:0]     imm_s32;
  logic [31:0]     imm_b32;
  logic [31:0]     imm_u32;
  logic [31:0]     imm_j32;
  logic [31:0]     shamt32;
  logic [31:0]     imm32;
  logic            zext_sel;
  fmt_e            fmt;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // All formats are first built as 32-bit signed values, then widened once.
  assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};
  assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

  // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
  assign shamt32 = (XLEN == 64) ? {26'b0, instr_i[25:20]}
                                : {27'b0, instr_i[24:20]};

  // Opcode to format/immediate selection; unknown opcodes are illegal.
  always_comb begin
    fmt       = FMT_NONE;
    imm32     = 32'b0;
    zext_sel  = 1'b0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = imm_i32;
      end
      OPC_OPIMM: begin
        fmt   = FMT_I;
        imm32 = imm_i32;
        if (SHAMT_ZEXT && ((funct3 == F3_SLL) || (funct3 == F3_SR))) begin
          zext_sel = 1'b1;
        end
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          fmt   = FMT_I;
          imm32 = imm_i32;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = imm_s32;
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = imm_b32;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = imm_u32;
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = imm_j32;
      end
      OPC_OP: begin
        fmt   = FMT_NONE;
        imm32 = 32'b0;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  // Widen to XLEN: sign extension for immediates, zero extension for shamt.
  generate
    if (XLEN == 64) begin : g_x64
      assign imm_sext = {{32{imm32[31]}}, imm32};
      assign imm_zext = {32'b0, shamt32};
    end else begin : g_x32
      assign imm_sext = imm32;
      assign imm_zext = shamt32;
    end
  endgenerate

  assign imm_o = zext_sel ? imm_zext : imm_sext;
  assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator behind a 2-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is a flop, so no combinational path runs from
// out_ready to in_ready, and out_* hold stable while out_valid & ~out_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter bit SHAMT_ZEXT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          new_entry;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            in_fire;
  logic            out_fire;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  imm_decode #(
    .XLEN       (XLEN),
    .SHAMT_ZEXT (SHAMT_ZEXT)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  assign new_entry = '{imm: dec_imm, fmt: dec_fmt, ill: dec_ill, tag: in_tag};
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;

  // Next-state of the two entries; the skid only fills while the output
  // entry is stalled, and in_ready is low whenever the skid is occupied.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_valid_q) begin
      if (out_fire && in_fire) begin
        out_d = new_entry;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end else if (in_fire) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else if (in_fire) begin
      out_d       = new_entry;
      out_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset also clears the data fields, flush does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three parameterisations driven in
// lockstep (RV32, RV64 with zero-extended shamt, RV32 with zero-extended
// shamt), decode table, backpressure, flush and reset checks.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready,    v_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [7:0]  tag_a;

  logic        in_ready_b,  v_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [7:0]  tag_b;

  logic        in_ready_c,  v_c, ill_c;
  logic [31:0] imm_c;
  logic [2:0]  fmt_c;
  logic [7:0]  tag_c;

  int n_vec = 0;
  int n_bad = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_ZEXT(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v_a), .out_ready(out_ready), .out_imm(imm_a), .out_fmt(fmt_a),
    .out_illegal(ill_a), .out_tag(tag_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHAMT_ZEXT(1'b1)) dut64z (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v_b), .out_ready(out_ready), .out_imm(imm_b), .out_fmt(fmt_b),
    .out_illegal(ill_b), .out_tag(tag_b)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_ZEXT(1'b1)) dut32z (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v_c), .out_ready(out_ready), .out_imm(imm_c), .out_fmt(fmt_c),
    .out_illegal(ill_c), .out_tag(tag_c)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed decode table: instr, RV32 imm/fmt/illegal, RV64+zext imm/fmt/illegal, RV32+zext imm
  logic [31:0] t_instr [12] = '{
    32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800002B7,
    32'h001000EF, 32'h00001017, 32'h00000000, 32'h002081B3,
    32'h0010009B, 32'hFFF00090, 32'h40105093, 32'h01F01093};
  logic [31:0] t_imm32 [12] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000,
    32'h00000800, 32'h00001000, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h00000401, 32'h0000001F};
  logic [2:0]  t_fmt32 [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
  logic        t_ill32 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] t_imm64 [12] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000,
    64'h800, 64'h1000, 64'h0, 64'h0,
    64'h1, 64'h0, 64'h1, 64'h1F};
  logic [2:0]  t_fmt64 [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
  logic        t_ill64 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] t_immz  [12] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000,
    32'h00000800, 32'h00001000, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h00000001, 32'h0000001F};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_valid"},    {63'b0, v_a},      64'd0);
    chk({pfx, "_imm"},      {32'b0, imm_a},    64'd0);
    chk({pfx, "_imm64"},    imm_b,             64'd0);
    chk({pfx, "_fmt"},      {61'b0, fmt_a},    64'd0);
    chk({pfx, "_illegal"},  {63'b0, ill_a},    64'd0);
    chk({pfx, "_tag"},      {56'b0, tag_a},    64'd0);
    chk({pfx, "_in_ready"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    step();
    step();
    reset = 1'b0;
    chk_reset_state("rst");

    // Back-to-back decode table with the output always ready
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, t_instr[i], 8'(8'h30 + i));
      step();
      chk($sformatf("tbl%0d_valid", i),  {63'b0, v_a},    64'd1);
      chk($sformatf("tbl%0d_imm", i),    {32'b0, imm_a},  {32'b0, t_imm32[i]});
      chk($sformatf("tbl%0d_fmt", i),    {61'b0, fmt_a},  {61'b0, t_fmt32[i]});
      chk($sformatf("tbl%0d_ill", i),    {63'b0, ill_a},  {63'b0, t_ill32[i]});
      chk($sformatf("tbl%0d_tag", i),    {56'b0, tag_a},  {56'b0, 8'(8'h30 + i)});
      chk($sformatf("tbl%0d_imm64", i),  imm_b,           t_imm64[i]);
      chk($sformatf("tbl%0d_fmt64", i),  {61'b0, fmt_b},  {61'b0, t_fmt64[i]});
      chk($sformatf("tbl%0d_ill64", i),  {63'b0, ill_b},  {63'b0, t_ill64[i]});
      chk($sformatf("tbl%0d_immz", i),   {32'b0, imm_c},  {32'b0, t_immz[i]});
    end
    drive(1'b0, 32'h0, 8'h0);
    step();
    chk("drain_valid", {63'b0, v_a}, 64'd0);

    // Backpressure: tags 1,2,3 with out_ready low for three cycles
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 8'd1);
    step();
    chk("bp_ready_1", {63'b0, in_ready}, 64'd1);
    chk("bp_tag_1",   {56'b0, tag_a},    64'd1);
    drive(1'b1, 32'hFE112E23, 8'd2);
    step();
    chk("bp_ready_2", {63'b0, in_ready}, 64'd0);
    chk("bp_hold_a",  {56'b0, tag_a},    64'd1);
    chk("bp_imm_a",   {32'b0, imm_a},    64'hFFFFFFFF);
    drive(1'b1, 32'hFE000CE3, 8'd3);
    step();
    chk("bp_hold_b",  {56'b0, tag_a},    64'd1);
    chk("bp_ready_3", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_drain_2",  {56'b0, tag_a},    64'd2);
    chk("bp_drain_2v", {63'b0, v_a},      64'd1);
    chk("bp_imm_2",    {32'b0, imm_a},    64'hFFFFFFFC);
    chk("bp_ready_4",  {63'b0, in_ready}, 64'd1);
    step();
    chk("bp_drain_3",  {56'b0, tag_a},    64'd3);
    chk("bp_imm_3",    {32'b0, imm_a},    64'hFFFFFFF8);
    drive(1'b0, 32'h0, 8'h0);
    step();
    chk("bp_empty", {63'b0, v_a}, 64'd0);

    // Flush with both entries full and a new instruction offered
    out_ready = 1'b0;
    drive(1'b1, 32'h800002B7, 8'h51);
    step();
    drive(1'b1, 32'h001000EF, 8'h52);
    step();
    chk("fl_full", {63'b0, in_ready}, 64'd0);
    drive(1'b1, 32'h00001017, 8'h53);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    chk("fl_valid", {63'b0, v_a},      64'd0);
    chk("fl_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), {63'b0, v_a}, 64'd0);
    end
    // Single entry held plus an input offered during flush: both dropped
    drive(1'b1, 32'hFFF00093, 8'h54);
    out_ready = 1'b0;
    step();
    drive(1'b1, 32'hFE112E23, 8'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    chk("fl2_valid", {63'b0, v_a}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("fl2_quiet", {63'b0, v_a}, 64'd0);
    // Pipe usable after flush
    drive(1'b1, 32'h00001017, 8'h56);
    step();
    drive(1'b0, 32'h0, 8'h0);
    chk("fl_resume_tag", {56'b0, tag_a}, 64'h56);
    chk("fl_resume_imm", {32'b0, imm_a}, 64'h1000);

    // Reset mid-stream with both entries occupied
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 8'h71);
    step();
    drive(1'b1, 32'hFE000CE3, 8'h72);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    chk_reset_state("mid_rst");
    out_ready = 1'b1;
    step();
    chk("mid_rst_quiet", {63'b0, v_a}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It covers every RV32/RV64 base immediate format: I, S, B, U and J. It also classifies the instruction format and flags illegal encodings. It sits between fetch and the register-read/ALU stage, behind a 2-entry skid buffer with a valid/ready handshake, so stalls propagate without combinational ready paths.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64. Immediates are sign-extended to XLEN.
TAG_W, 8, width of the sideband tag (PC index, ROB id) carried alongside each instruction.
SHAMT_ZEXT, 0, when 1, OP-IMM shifts (funct3 001/101) output the zero-extended shamt instead of the sign-extended I immediate.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush; drops all held entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  upstream may transfer; registered
in_instr  in  32  instruction word
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  format code (see package)
out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11
out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_tag=0, in_ready=1, skid buffer empty.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle. A transfer at edge N makes the decoded result visible at out_* after edge N.
- Output stability: while out_valid & ~out_ready, all out_* hold stable.
- Storage: 2 entries, the output register plus one skid register.
  - in_ready deasserts, registered, when both entries are full.
  - in_ready reasserts the cycle after an output transfer frees a slot.
  - No entry is lost or duplicated, and order is preserved.
  - Simultaneous input and output transfer at full occupancy is impossible, because in_ready is 0 at full occupancy.
  - Simultaneous input and output transfer below full occupancy keeps occupancy unchanged.
- Decode happens before storage; the skid register holds decoded fields.
- Opcode to format mapping:
  - 0000011, 0010011, 1100111, 1110011 map to I.
  - 0100011 maps to S.
  - 1100011 maps to B.
  - 0110111, 0010111 map to U.
  - 1101111 maps to J.
  - 0110011 maps to NONE with imm=0.
  - 0011011 (OP-IMM-32) maps to I only when XLEN=64; it is illegal when XLEN=32.
  - Any other opcode maps to NONE with imm=0 and out_illegal=1.
- Immediate construction (sext means sign-extend to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Shift amounts with SHAMT_ZEXT=1: shamt is instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64, zero-extended.
- Flush:
  - At the next edge, both entries are invalidated, out_valid=0 and in_ready=1.
  - An in_valid presented in the flush cycle is dropped.
  - Flush takes priority over all transfers in the same cycle.
- Reset mid-operation: identical to flush, and additionally clears the data registers to their reset values.

Decomposition:
- Package imm_gen_pkg contains:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP);
  - typedef enum logic [2:0] fmt_e: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
- One combinational sub-module, imm_decode, parametrised by XLEN and SHAMT_ZEXT. It maps instr to {imm, fmt, illegal}.
- imm_gen_pipe itself contains only the skid buffer and control.

Test Plan:
1. addi 0xFFF00093, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_fmt=FMT_I, out_illegal=0; tag echoed.
2. sw 0xFE112E23 then beq 0xFE000CE3 back-to-back -> out_imm 0xFFFFFFFC (FMT_S) then 0xFFFFFFF8 (FMT_B) on consecutive cycles.
3. lui 0x800002B7 -> out_imm 0x80000000 with XLEN=32, 0xFFFFFFFF80000000 with XLEN=64; FMT_U. With SHAMT_ZEXT=1 and XLEN=32, slli 0x01F01093 -> out_imm 0x0000001F.
4. Backpressure: tags 1,2,3 streamed with out_ready=0 for 3 cycles.
   - in_ready falls after tags 1 and 2 are accepted.
   - out holds tag 1 stable.
   - On release, tags 1, 2, 3 drain in order with no gaps once the pipe is full.
5. Flush with both entries full and in_valid=1 -> next cycle out_valid=0 and in_ready=1; no dropped tag ever appears at out_tag.
6. Illegal cases:
   - 0x00000000 -> out_illegal=1, out_fmt=FMT_NONE, out_imm=0.
   - add 0x002081B3 -> out_illegal=0, out_imm=0.
   - Reset asserted mid-stream -> all outputs at reset values after the edge.
